// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache line parameters, line type and responder state
package cache_pkg;

  localparam int NrWordsPerLine = 4;
  localparam int LineSize       = 32 * NrWordsPerLine;
  localparam int ByteOffsetBits = 4;

  typedef logic [NrWordsPerLine-1:0][31:0] line_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/line_mem_array.sv
// rtl/line_mem_array.sv - word-write, full-line read backing store, never reset
module line_mem_array
  import cache_pkg::*;
#(
  parameter int DepthWords = 1024,
  parameter int IdxW       = $clog2(DepthWords)
) (
  input  logic            clk_i,
  input  logic            wr_en_i,
  input  logic [IdxW-1:0] wr_idx_i,
  input  logic [31:0]     wr_data_i,
  input  logic [IdxW-1:0] rd_base_i,
  output line_t           rd_line_o
);

  localparam int SelW = $clog2(NrWordsPerLine);

  logic [31:0] mem_q [DepthWords];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Combinational read: a same-edge write is not yet visible, so a load sees the old word.
  always_comb begin
    for (int i = 0; i < NrWordsPerLine; i++) begin
      rd_line_o[i] = mem_q[{rd_base_i[IdxW-1:SelW], SelW'(i)}];
    end
  end

endmodule

// File: rtl/line_mem_responder.sv
// rtl/line_mem_responder.sv - fixed-latency line refill responder for the cache
module line_mem_responder
  import cache_pkg::*;
#(
  parameter int DepthWords = 1024,
  parameter int Latency    = 4
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [31:0]         mem_addr_i,
  input  logic                mem_read_en_i,
  output logic                mem_read_valid_o,
  output logic [LineSize-1:0] mem_read_data_o,
  input  logic                wr_en_i,
  input  logic [31:0]         wr_addr_i,
  input  logic [31:0]         wr_data_i,
  output logic                busy_o
);

  localparam int IdxW = $clog2(DepthWords);
  localparam int SelW = $clog2(NrWordsPerLine);

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [IdxW-1:0] base_q, base_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  line_t           data_q, data_d;

  logic [IdxW-1:0] req_base;
  logic [IdxW-1:0] wr_idx;
  logic [IdxW-1:0] rd_base;
  line_t           rd_line;
  logic            unused_addr_bits;

  // Upper address bits fall away, so indices wrap modulo the depth.
  assign req_base = {mem_addr_i[IdxW+1:2+SelW], SelW'(0)};
  assign wr_idx   = wr_addr_i[IdxW+1:2];
  assign unused_addr_bits = ^{mem_addr_i[31:IdxW+2], mem_addr_i[1+SelW:0],
                              wr_addr_i[31:IdxW+2], wr_addr_i[1:0]};

  // With Latency 1 the load happens straight from IDLE, before base_q holds the address.
  assign rd_base = (state_q == IDLE) ? req_base : base_q;

  line_mem_array #(
    .DepthWords (DepthWords),
    .IdxW       (IdxW)
  ) u_array (
    .clk_i     (clk_i),
    .wr_en_i   (wr_en_i),
    .wr_idx_i  (wr_idx),
    .wr_data_i (wr_data_i),
    .rd_base_i (rd_base),
    .rd_line_o (rd_line)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (mem_read_en_i) begin
          base_d = req_base;
          if (Latency == 1) begin
            state_d = RESP;
            data_d  = rd_line;
          end else begin
            state_d = WAIT;
            cnt_d   = 8'(Latency - 1);
          end
        end
      end
      WAIT: begin
        if (!mem_read_en_i) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'd1) begin
          state_d = RESP;
          cnt_d   = 8'd0;
          data_d  = rd_line;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    valid_d = (state_d == RESP);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      base_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
    end
  end

  assign mem_read_valid_o = valid_q;
  assign mem_read_data_o  = data_q;
  assign busy_o           = busy_q;

endmodule
